// File: rtl/shift_deserializer_if.sv
// shift_deserializer_if: serial-link and word-side handshake bundle for
// shift_deserializer.
//   si, bit_valid, abort      serial bit stream, strobe and frame abort
//   data, data_valid          received word and its valid flag
//   data_ready                consumer accept
//   par_err                   parity result for the word on data
//   overrun, clr_ovr          sticky dropped-word flag and its clear
//   busy                      receiver is inside a frame
// Modport master is the receiver; slave is the link driver / consumer.
interface shift_deserializer_if #(
   parameter int unsigned N = 4
);
   logic         si;
   logic         bit_valid;
   logic         abort;
   logic [N-1:0] data;
   logic         data_valid;
   logic         data_ready;
   logic         par_err;
   logic         overrun;
   logic         clr_ovr;
   logic         busy;

   modport master (
      input  si, bit_valid, abort, data_ready, clr_ovr,
      output data, data_valid, par_err, overrun, busy
   );

   modport slave (
      output si, bit_valid, abort, data_ready, clr_ovr,
      input  data, data_valid, par_err, overrun, busy
   );
endinterface

// File: rtl/shift_deserializer.sv
// shift_deserializer: LSB-first serial-to-parallel receiver with a registered
// valid/ready word output, sticky overrun flag and optional parity check.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      shift_deserializer_if.master (si, bit_valid, abort, data,
//            data_valid, data_ready, par_err, overrun, clr_ovr, busy)
// Build option: define DESER_PARITY_EN to append one even-parity bit to each
// frame and report par_err; otherwise frames are N data bits and par_err = 0.
module shift_deserializer #(
   parameter int unsigned N = 4
) (
   input  logic                   clk,
   input  logic                   reset_n,
   shift_deserializer_if.master   bus
);
   localparam int unsigned CW = $clog2(N + 1);

`ifdef DESER_PARITY_EN
   typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
   typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

   state_t        state;
   logic [CW-1:0] bit_cnt;
   logic [N-1:0]  shift_reg;
   logic [N-1:0]  shift_in;
   logic          word_done;
   logic [N-1:0]  word_next;
   logic          par_next;
   logic          load_ok;

   always_comb begin
      shift_in  = {bus.si, shift_reg[N-1:1]};
      word_done = 1'b0;
      word_next = shift_in;
      par_next  = 1'b0;
`ifdef DESER_PARITY_EN
      // Data bits are already in shift_reg; this strobe carries the parity bit.
      word_done = bus.bit_valid && !bus.abort && (state == PARITY);
      word_next = shift_reg;
      par_next  = (^shift_reg) ^ bus.si;
`else
      word_done = bus.bit_valid && !bus.abort && (state == SHIFT) &&
                  (bit_cnt == CW'(N - 1));
`endif
      load_ok = !bus.data_valid || bus.data_ready;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= IDLE;
         bit_cnt        <= '0;
         shift_reg      <= '0;
         bus.busy       <= 1'b0;
         bus.data       <= '0;
         bus.data_valid <= 1'b0;
         bus.par_err    <= 1'b0;
         bus.overrun    <= 1'b0;
      end else begin
         // Frame FSM
         if (bus.abort) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift_reg <= '0;
            bus.busy  <= 1'b0;
         end else if (bus.bit_valid) begin
            case (state)
               IDLE: begin
                  shift_reg <= shift_in;
                  bit_cnt   <= CW'(1);
                  state     <= SHIFT;
                  bus.busy  <= 1'b1;
               end
               SHIFT: begin
                  shift_reg <= shift_in;
                  if (bit_cnt == CW'(N - 1)) begin
                     bit_cnt <= '0;
`ifdef DESER_PARITY_EN
                     state    <= PARITY;
                     bus.busy <= 1'b1;
`else
                     state    <= IDLE;
                     bus.busy <= 1'b0;
`endif
                  end else begin
                     bit_cnt <= bit_cnt + CW'(1);
                  end
               end
`ifdef DESER_PARITY_EN
               PARITY: begin
                  state    <= IDLE;
                  bus.busy <= 1'b0;
               end
`endif
               default: begin
                  state    <= IDLE;
                  bus.busy <= 1'b0;
               end
            endcase
         end

         // Output register and handshake; a completing word and a same-cycle
         // accept load back-to-back without a bubble.
         if (word_done && load_ok) begin
            bus.data       <= word_next;
            bus.par_err    <= par_next;
            bus.data_valid <= 1'b1;
         end else if (bus.data_valid && bus.data_ready) begin
            bus.data_valid <= 1'b0;
         end

         // Set wins over clear.
         if (word_done && !load_ok)
            bus.overrun <= 1'b1;
         else if (bus.clr_ovr)
            bus.overrun <= 1'b0;
      end
   end
endmodule

// File: tb/tb_shift_deserializer.sv
module tb_shift_deserializer;
   localparam int unsigned N = 4;
`ifdef DESER_PARITY_EN
   localparam int unsigned PAR = 1;
`else
   localparam int unsigned PAR = 0;
`endif
   localparam int unsigned FL = N + PAR;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   shift_deserializer_if #(.N(N)) bus ();

   shift_deserializer #(.N(N)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit           bq[$];
   logic [N-1:0] m_data;
   logic         m_valid, m_par, m_ovr, m_busy;

   always @(posedge clk or negedge reset_n) begin
      bit done, setf, p;
      logic [N-1:0] w;
      if (!reset_n) begin
         bq.delete();
         m_data = '0; m_valid = 0; m_par = 0; m_ovr = 0; m_busy = 0;
      end else begin
         done = 0; setf = 0; p = 0; w = '0;
         if (bus.abort) bq.delete();
         else if (bus.bit_valid) begin
            bq.push_back(bus.si);
            if (bq.size() == FL) begin
               done = 1;
               for (int i = 0; i < N; i++) w[i] = bq[i];
               for (int i = 0; i < FL; i++) p ^= bq[i];
               bq.delete();
            end
         end
         if (done) begin
            if (!m_valid || bus.data_ready) begin
               m_data = w; m_par = (PAR != 0) ? p : 1'b0; m_valid = 1;
            end else setf = 1;
         end else if (m_valid && bus.data_ready) m_valid = 0;
         if (setf) m_ovr = 1;
         else if (bus.clr_ovr) m_ovr = 0;
         m_busy = (bq.size() != 0);
      end
   end

   // ---------------- per-cycle comparison ----------------
   always @(negedge clk) begin
      chk("data", bus.data, m_data);
      chk("data_valid", bus.data_valid, m_valid);
      chk("par_err", bus.par_err, m_par);
      chk("overrun", bus.overrun, m_ovr);
      chk("busy", bus.busy, m_busy);
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input logic bv, input logic b, input logic ab);
      bus.bit_valid = bv; bus.si = b; bus.abort = ab;
      @(negedge clk);
      bus.bit_valid = 0; bus.abort = 0;
   endtask

   function automatic logic fbit(input logic [N-1:0] w, input logic badp, input int i);
      if (i < N) return w[i];
      return (^w) ^ badp;
   endfunction

   task automatic send_word(input logic [N-1:0] w, input logic badp);
      for (int i = 0; i < FL; i++) cyc(1, fbit(w, badp, i), 0);
   endtask

   initial begin
      bus.si = 0; bus.bit_valid = 0; bus.abort = 0;
      bus.data_ready = 0; bus.clr_ovr = 0;
      repeat (2) @(negedge clk);
      chk("rst_data", bus.data, 0);
      chk("rst_valid", bus.data_valid, 0);
      chk("rst_busy", bus.busy, 0);
      #3 reset_n = 1;
      @(negedge clk);

      // 1,0,1,1 LSB first -> 4'b1101, valid for exactly one cycle
      bus.data_ready = 1;
      for (int i = 0; i < FL - 1; i++) cyc(1, fbit(4'hD, 0, i), 0);
      chk("t1_valid_early", bus.data_valid, 0);
      cyc(1, fbit(4'hD, 0, FL - 1), 0);
      chk("t1_data", bus.data, 4'hD);
      chk("t1_model", m_data, 4'hD);
      chk("t1_valid", bus.data_valid, 1);
      cyc(0, 0, 0);
      chk("t1_valid_drop", bus.data_valid, 0);

      // overrun
      bus.data_ready = 0;
      send_word(4'hA, 0);
      send_word(4'h5, 0);
      chk("t2_data", bus.data, 4'hA);
      chk("t2_valid", bus.data_valid, 1);
      chk("t2_ovr", bus.overrun, 1);
      bus.clr_ovr = 1; cyc(0, 0, 0); bus.clr_ovr = 0;
      chk("t2_ovr_clr", bus.overrun, 0);
      bus.data_ready = 1; cyc(0, 0, 0);
      chk("t2_drain", bus.data_valid, 0);

      // back-to-back 0x3 then 0xC
      bus.data_ready = 0;
      send_word(4'h3, 0);
      chk("t3_first", bus.data, 4'h3);
      for (int i = 0; i < FL - 1; i++) begin
         cyc(1, fbit(4'hC, 0, i), 0);
         chk("t3_hold_valid", bus.data_valid, 1);
         chk("t3_hold_data", bus.data, 4'h3);
      end
      bus.data_ready = 1;
      cyc(1, fbit(4'hC, 0, FL - 1), 0);
      chk("t3_valid", bus.data_valid, 1);
      chk("t3_data", bus.data, 4'hC);
      chk("t3_ovr", bus.overrun, 0);
      cyc(0, 0, 0);

      // abort mid frame
      cyc(1, 1, 0); cyc(1, 1, 0);
      cyc(1, 1, 1);
      chk("t4_busy", bus.busy, 0);
      send_word(4'h9, 0);
      chk("t4_data", bus.data, 4'h9);
      chk("t4_valid", bus.data_valid, 1);
      cyc(0, 0, 0);

      // async reset mid frame
      bus.data_ready = 0;
      send_word(4'h9, 0);
      cyc(1, 0, 0); cyc(1, 1, 0); cyc(1, 1, 0);
      #3 reset_n = 0;
      #1;
      chk("t5_data", bus.data, 0);
      chk("t5_valid", bus.data_valid, 0);
      chk("t5_busy", bus.busy, 0);
      @(negedge clk);
      #3 reset_n = 1;
      @(negedge clk);
      send_word(4'h6, 0);
      chk("t5_word", bus.data, 4'h6);
      chk("t5_wvalid", bus.data_valid, 1);
      bus.data_ready = 1; cyc(0, 0, 0);

`ifdef DESER_PARITY_EN
      send_word(4'h7, 0);
      chk("p_good_data", bus.data, 4'h7);
      chk("p_good_err", bus.par_err, 0);
      send_word(4'h7, 1);
      chk("p_bad_err", bus.par_err, 1);
      chk("p_bad_valid", bus.data_valid, 1);
      cyc(0, 0, 0);
`endif

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         bus.data_ready = ($urandom_range(0, 9) < 6);
         bus.clr_ovr    = ($urandom_range(0, 19) == 0);
         cyc($urandom_range(0, 9) < 7, 1'($urandom), $urandom_range(0, 29) == 0);
      end
      bus.clr_ovr = 0;
      repeat (2) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
